bf16_div_lane_packer: RTL

//  Upstream feeder for the N-lane parameterized bfloat16 divider array.

---
 rtl/bf16_div_lane_packer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bf16_div_lane_packer.sv
// bf16_div_lane_packer
//   Feeds an N-lane bfloat16 divider array. Operand pairs arrive one per cycle on a
//   valid/ready stream and are packed lane 0 first into a1/b1. A vector issues when
//   lane N-1 fills, or early on flush. Unfilled lanes carry PAD (1.0) so the divider
//   sees harmless operands there. A DIV_LAT-deep shadow pipe carries {valid, mask}
//   alongside the divider so downstream logic knows which c1 lanes are real, and when.
// Ports
//   clk1, rst1_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand stream handshake (in_ready is 1 after reset release)
//   in_a, in_b            bf16 dividend / divisor
//   flush                 issue a partially filled vector now
//   a1, b1                packed operands to the divider, lane i = bits [16i+15:16i]
//   issue_valid           one-cycle pulse per issued vector
//   issue_mask            bit i set = lane i holds a real pair
//   res_valid, res_mask   issue_valid/issue_mask delayed by DIV_LAT cycles
module bf16_div_lane_packer #(
  parameter int unsigned N       = 2,
  parameter int unsigned DIV_LAT = 1,
  parameter logic [15:0] PAD     = 16'h3F80
) (
  input  logic             clk1,
  input  logic             rst1_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             flush,
  output logic [16*N-1:0]  a1,
  output logic [16*N-1:0]  b1,
  output logic             issue_valid,
  output logic [N-1:0]     issue_mask,
  output logic             res_valid,
  output logic [N-1:0]     res_mask
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LastIdx = CW'(N - 1);

  typedef enum logic [0:0] {StEmpty, StFilling} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   buf_a_q [N];
  logic [15:0]   buf_b_q [N];

  logic              accept;
  logic              issue;
  logic [16*N-1:0]   a_d;
  logic [16*N-1:0]   b_d;
  logic [N-1:0]      mask_d;

  logic              pipe_v_q [DIV_LAT];
  logic [N-1:0]      pipe_m_q [DIV_LAT];

  // Issue vector: buffered lanes, then this cycle's pair (if accepted), then PAD.
  always_comb begin
    accept = in_valid & in_ready;
    issue  = (accept && (cnt_q == LastIdx)) || (flush && ((cnt_q != '0) || accept));
    a_d    = '0;
    b_d    = '0;
    mask_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (CW'(i) < cnt_q) begin
        a_d[16*i +: 16] = buf_a_q[i];
        b_d[16*i +: 16] = buf_b_q[i];
        mask_d[i]       = 1'b1;
      end else if ((CW'(i) == cnt_q) && accept) begin
        a_d[16*i +: 16] = in_a;
        b_d[16*i +: 16] = in_b;
        mask_d[i]       = 1'b1;
      end else begin
        a_d[16*i +: 16] = PAD;
        b_d[16*i +: 16] = PAD;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      state_q     <= StEmpty;
      cnt_q       <= '0;
      in_ready    <= 1'b0;
      a1          <= {N{PAD}};
      b1          <= {N{PAD}};
      issue_valid <= 1'b0;
      issue_mask  <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        buf_a_q[i] <= '0;
        buf_b_q[i] <= '0;
      end
    end else begin
      // The divider array never back-pressures, so ready just follows reset release.
      in_ready    <= 1'b1;
      issue_valid <= issue;

      unique case (state_q)
        StEmpty:   if (accept && !issue) state_q <= StFilling;
        StFilling: if (issue)            state_q <= StEmpty;
        default:                         state_q <= StEmpty;
      endcase

      if (issue) begin
        a1         <= a_d;
        b1         <= b_d;
        issue_mask <= mask_d;
        cnt_q      <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
      end

      for (int unsigned i = 0; i < N; i++) begin
        if (accept && !issue && (cnt_q == CW'(i))) begin
          buf_a_q[i] <= in_a;
          buf_b_q[i] <= in_b;
        end
      end
    end
  end

  // Shadow pipe mirrors the divider latency.
  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      for (int unsigned k = 0; k < DIV_LAT; k++) begin
        pipe_v_q[k] <= 1'b0;
        pipe_m_q[k] <= '0;
      end
    end else begin
      pipe_v_q[0] <= issue_valid;
      pipe_m_q[0] <= issue_mask;
      for (int unsigned k = 1; k < DIV_LAT; k++) begin
        pipe_v_q[k] <= pipe_v_q[k-1];
        pipe_m_q[k] <= pipe_m_q[k-1];
      end
    end
  end

  assign res_valid = pipe_v_q[DIV_LAT-1];
  assign res_mask  = pipe_m_q[DIV_LAT-1];

endmodule
